// File: rtl/riscv_apu_arbiter.sv
// Shared-APU arbiter: round-robin selection of core dispatcher requests onto
// one APU channel. An in-order tag FIFO records which core owns each
// outstanding multicycle operation, so every result goes back to its owner.
module riscv_apu_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 128,
    parameter int RESP_W    = 32,
    parameter int TAG_DEPTH = 4,
    parameter int ID_W      = $clog2(NUM_CORES)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_CORES-1:0]              core_req_i,
    input  logic [NUM_CORES-1:0][DATA_W-1:0]  core_data_i,
    output logic [NUM_CORES-1:0]              core_gnt_o,
    output logic [NUM_CORES-1:0]              core_rvalid_o,
    output logic [RESP_W-1:0]                 core_rdata_o,
    output logic                              apu_req_o,
    output logic [DATA_W-1:0]                 apu_data_o,
    input  logic                              apu_gnt_i,
    input  logic                              apu_rvalid_i,
    input  logic [RESP_W-1:0]                 apu_rdata_i,
    output logic                              busy_o,
    output logic                              contention_o,
    output logic                              err_o
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             empty;
    logic             any_req;
    logic             found;
    logic             accept;
    logic             pop;
    logic             single;
    logic             push;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  head;
    logic [ID_W-1:0]  rr_next;

    assign full    = (count == CNT_W'(TAG_DEPTH));
    assign empty   = (count == '0);
    assign any_req = |core_req_i;

    // A full FIFO blocks issue even when a pop happens in the same cycle;
    // this keeps the issue path independent of the response path.
    assign apu_req_o  = any_req & ~full;
    assign apu_data_o = core_data_i[winner];
    assign accept     = apu_req_o & apu_gnt_i;

    assign head   = tag_mem[rd_ptr];
    assign pop    = apu_rvalid_i & ~empty;
    // A result in the same cycle as an accept with nothing outstanding
    // belongs to that accepted op, which then never enters the FIFO.
    assign single = apu_rvalid_i & empty & accept;
    assign push   = accept & ~single;
    assign err_o  = apu_rvalid_i & empty & ~accept;

    assign busy_o       = ~empty;
    assign core_rdata_o = apu_rdata_i;
    assign contention_o = accept & ($countones(core_req_i) > 1);
    assign rr_next      = (winner == ID_W'(NUM_CORES - 1)) ? '0 : winner + ID_W'(1);

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!found && core_req_i[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // One-hot grant to the winner and response steering to the owner.
    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        if (accept) core_gnt_o[winner] = 1'b1;
        if (pop) begin
            core_rvalid_o[head] = 1'b1;
        end else if (single) begin
            core_rvalid_o[winner] = 1'b1;
        end
    end

    // Arbitration pointer and FIFO bookkeeping; reset discards outstanding tags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) rr_ptr <= rr_next;
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Owner-ID storage; only meaningful between the pointers, so never reset.
    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr] <= winner;
    end

endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// Bench for riscv_apu_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the arbiter.
module tb_riscv_apu_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int RW = 32;
    localparam int TD = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           req;
    logic [N-1:0][DW-1:0]   data;
    logic [N-1:0]           gnt;
    logic [N-1:0]           rvalid;
    logic [RW-1:0]          rdata;
    logic                   apu_req;
    logic [DW-1:0]          apu_data;
    logic                   apu_gnt;
    logic                   apu_rvalid;
    logic [RW-1:0]          apu_rdata;
    logic                   busy;
    logic                   cont;
    logic                   err;

    int errors = 0;
    int checks = 0;

    // reference model state: next-preferred core and queue of owners
    int rr;
    int q[$];
    logic [N-1:0] last_gnt;

    // values observed on the most recent cycle
    logic [N-1:0]  o_gnt;
    logic [N-1:0]  o_rv;
    logic          o_req;
    logic [DW-1:0] o_data;
    logic          o_busy;
    logic          o_cont;
    logic          o_err;

    always #5 clk = ~clk;

    riscv_apu_arbiter #(
        .NUM_CORES (N),
        .DATA_W    (DW),
        .RESP_W    (RW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .core_req_i    (req),
        .core_data_i   (data),
        .core_gnt_o    (gnt),
        .core_rvalid_o (rvalid),
        .core_rdata_o  (rdata),
        .apu_req_o     (apu_req),
        .apu_data_o    (apu_data),
        .apu_gnt_i     (apu_gnt),
        .apu_rvalid_i  (apu_rvalid),
        .apu_rdata_i   (apu_rdata),
        .busy_o        (busy),
        .contention_o  (cont),
        .err_o         (err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, compare just after, then let the
    // model take the step the rising edge will take in the DUT.
    task automatic cycle(input logic r_n, input logic [N-1:0] rq, input logic [N-1:0][DW-1:0] d,
                         input logic g, input logic rv, input logic [RW-1:0] rd);
        int           win;
        bit           full;
        bit           acc;
        bit           pop;
        bit           single;
        logic [N-1:0] one;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rv;
        logic [DW-1:0] e_data;
        bit           e_err;
        bit           e_cont;
        @(negedge clk);
        rst_n = r_n; req = rq; data = d; apu_gnt = g; apu_rvalid = rv; apu_rdata = rd;
        #1;
        o_gnt = gnt; o_rv = rvalid; o_req = apu_req; o_data = apu_data;
        o_busy = busy; o_cont = cont; o_err = err;
        last_gnt = '0;
        if (!r_n) begin
            rr = 0;
            q.delete();
        end else begin
            one = 1;
            win = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr + k) % N;
                if (rq[c]) begin
                    win = c;
                    break;
                end
            end
            full   = (q.size() == TD);
            acc    = (win >= 0) && !full && g;
            e_gnt  = acc ? (one << win) : '0;
            e_data = (win >= 0) ? d[win] : d[0];
            e_rv   = '0;
            e_err  = 1'b0;
            pop    = 1'b0;
            single = 1'b0;
            if (rv && q.size() > 0) begin
                e_rv = one << q[0];
                pop  = 1'b1;
            end else if (rv && acc) begin
                e_rv   = one << win;
                single = 1'b1;
            end else if (rv) begin
                e_err = 1'b1;
            end
            e_cont = acc && ($countones(rq) > 1);
            chk("gnt",        DW'(o_gnt),  DW'(e_gnt));
            chk("rvalid",     DW'(o_rv),   DW'(e_rv));
            chk("rdata",      DW'(rdata),  DW'(rd));
            chk("apu_req",    DW'(o_req),  DW'((win >= 0) && !full));
            chk("apu_data",   o_data,      e_data);
            chk("busy",       DW'(o_busy), DW'(q.size() > 0));
            chk("contention", DW'(o_cont), DW'(e_cont));
            chk("err",        DW'(o_err),  DW'(e_err));
            last_gnt = e_gnt;
            if (pop) void'(q.pop_front());
            if (acc && !single) q.push_back(win);
            if (acc) rr = (win + 1) % N;
        end
    endtask

    initial begin
        logic [N-1:0][DW-1:0] dd;
        logic [N-1:0][DW-1:0] rd_data;
        logic [N-1:0]         rq;
        logic [N-1:0]         exp_g [4];

        for (int k = 0; k < N; k++) dd[k] = {4{32'hA000_0000 + 32'(k)}};
        rst_n = 1'b0; req = '0; data = '0; apu_gnt = 1'b0; apu_rvalid = 1'b0; apu_rdata = '0;
        rr = 0;

        // power-on reset
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);
        cycle(1'b1, '0, '0, 1'b0, 1'b0, '0);
        chk("rst_gnt",  DW'(o_gnt),  '0);
        chk("rst_req",  DW'(o_req),  '0);
        chk("rst_busy", DW'(o_busy), '0);
        chk("rst_err",  DW'(o_err),  '0);

        // cores 0 and 2 request, APU always grants, no responses
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001; exp_g[3] = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'b0101, dd, 1'b1, 1'b0, '0);
            chk("fill_gnt",  DW'(o_gnt),  DW'(exp_g[i]));
            chk("fill_cont", DW'(o_cont), DW'(1'b1));
        end
        cycle(1'b1, 4'b0101, dd, 1'b1, 1'b0, '0);
        chk("full_req", DW'(o_req), '0);
        chk("full_gnt", DW'(o_gnt), '0);

        // drain with one response per cycle; issue resumes one cycle after the first pop
        cycle(1'b1, 4'b0101, dd, 1'b1, 1'b1, 32'h1111);
        chk("drain_rv0",  DW'(o_rv),  DW'(4'b0001));
        chk("drain_req0", DW'(o_req), '0);
        cycle(1'b1, 4'b0101, dd, 1'b1, 1'b1, 32'h2222);
        chk("drain_rv1",  DW'(o_rv),  DW'(4'b0100));
        chk("resume_gnt", DW'(o_gnt), DW'(4'b0001));
        cycle(1'b1, '0, dd, 1'b0, 1'b1, 32'h3333);
        chk("drain_rv2", DW'(o_rv), DW'(4'b0001));
        cycle(1'b1, '0, dd, 1'b0, 1'b1, 32'h4444);
        chk("drain_rv3", DW'(o_rv), DW'(4'b0100));
        cycle(1'b1, '0, dd, 1'b0, 1'b1, 32'h5555);
        chk("drain_rv4",   DW'(o_rv),   DW'(4'b0001));
        chk("drain_busy4", DW'(o_busy), DW'(1'b1));
        cycle(1'b1, '0, dd, 1'b0, 1'b0, '0);
        chk("drained_busy", DW'(o_busy), '0);

        // single-cycle op from core 3 on an empty FIFO
        cycle(1'b1, 4'b1000, dd, 1'b1, 1'b1, 32'hCAFE);
        chk("single_rv",   DW'(o_rv),   DW'(4'b1000));
        chk("single_err",  DW'(o_err),  '0);
        chk("single_data", o_data,      dd[3]);
        cycle(1'b1, '0, dd, 1'b0, 1'b0, '0);
        chk("single_busy", DW'(o_busy), '0);

        // APU stalls for three cycles, then cores 1 and 3 alternate
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b1010, dd, 1'b0, 1'b0, '0);
            chk("stall_gnt", DW'(o_gnt), '0);
            chk("stall_req", DW'(o_req), DW'(1'b1));
        end
        cycle(1'b1, 4'b1010, dd, 1'b1, 1'b0, '0);
        chk("unstall_gnt1", DW'(o_gnt), DW'(4'b0010));
        cycle(1'b1, 4'b1010, dd, 1'b1, 1'b0, '0);
        chk("unstall_gnt3", DW'(o_gnt), DW'(4'b1000));

        // reset with two ops outstanding
        cycle(1'b0, '0, dd, 1'b0, 1'b0, '0);
        cycle(1'b1, '0, dd, 1'b0, 1'b0, '0);
        chk("mrst_busy", DW'(o_busy), '0);
        cycle(1'b1, 4'b1001, dd, 1'b0, 1'b0, '0);
        chk("mrst_rr_data", o_data, dd[0]);

        // stray response with nothing outstanding and no accept
        cycle(1'b1, '0, dd, 1'b0, 1'b1, 32'hDEAD);
        chk("stray_err", DW'(o_err), DW'(1'b1));
        chk("stray_rv",  DW'(o_rv),  '0);
        cycle(1'b1, '0, dd, 1'b0, 1'b0, '0);
        chk("stray_err_clr", DW'(o_err), '0);

        // random traffic; requests are held until granted
        rq = '0;
        rd_data = dd;
        for (int i = 0; i < 3000; i++) begin
            rq = rq & ~last_gnt;
            for (int k = 0; k < N; k++) begin
                if (!rq[k]) begin
                    rd_data[k] = {$urandom, $urandom, $urandom, $urandom};
                    if ($urandom_range(0, 2) == 0) rq[k] = 1'b1;
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                rq = '0;
                cycle(1'b0, '0, rd_data, 1'b0, 1'b0, '0);
            end else begin
                cycle(1'b1, rq, rd_data, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 99) < 35), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_apu_arbiter.md
Name: riscv_apu_arbiter

Overview:
- Shares one APU (FPU / shared multiplier / divider) between NUM_CORES core-side APU dispatchers.
- Round-robin arbitration of dispatcher requests onto the single APU request/grant channel.
- Records the owner of every multicycle operation in an in-order tag FIFO and routes each APU response back to that core.
- Sits between the per-core dispatchers and the shared APU cluster interconnect.

Parameters:
- NUM_CORES, 4, number of requesting dispatchers (2..8).
- DATA_W, 128, width of the opaque request payload (operands, op, flags, type), passed through unchanged.
- RESP_W, 32, width of the result payload.
- TAG_DEPTH, 4, maximum outstanding multicycle operations (power of 2, >= 2).
- ID_W, $clog2(NUM_CORES), width of a requester ID.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- core_req_i  in  NUM_CORES  request from each dispatcher; held stable until granted.
- core_data_i  in  NUM_CORES x DATA_W  payload per core.
- core_gnt_o  out  NUM_CORES  one-hot grant, combinational.
- core_rvalid_o  out  NUM_CORES  one-hot response valid.
- core_rdata_o  out  RESP_W  response payload, broadcast to all cores.
- apu_req_o  out  1  request to the shared APU.
- apu_data_o  out  DATA_W  payload of the winning core.
- apu_gnt_i  in  1  APU accepts the request.
- apu_rvalid_i  in  1  APU result valid, always in issue order.
- apu_rdata_i  in  RESP_W  APU result.
- busy_o  out  1  FIFO not empty (outstanding ops).
- contention_o  out  1  perf pulse: accepted transfer while more than one core is requesting.
- err_o  out  1  pulse: response arrived with no owner.

Behaviour:
- State: rr_ptr (ID_W), tag FIFO (TAG_DEPTH x ID_W, with wr_ptr, rd_ptr, count of $clog2(TAG_DEPTH)+1 bits).
- Reset (rst_ni=0 at a clock edge): rr_ptr=0, pointers=0, count=0. During and after reset, with no requests pending, every output is 0.
- full = (count==TAG_DEPTH). empty = (count==0).
- Winner selection: first k with core_req_i[k]=1, searching from rr_ptr upward and wrapping modulo NUM_CORES.
- apu_req_o = any core_req_i & !full. apu_data_o = core_data_i[winner]; when there is no winner, apu_data_o is core_data_i[0].
- core_gnt_o[winner] = apu_gnt_i & apu_req_o. All other grants are 0.
- accept = apu_req_o & apu_gnt_i. On accept, rr_ptr <= winner+1, wrapping to 0 after NUM_CORES-1. Without accept, rr_ptr holds.
- Full FIFO: no request is issued, even if a pop happens in the same cycle. This gives one bubble after full; the bubble is intentional.
- Response routing, evaluated in this priority order:
  - apu_rvalid_i & !empty: route to the FIFO head. core_rvalid_o[head]=1, pop.
  - apu_rvalid_i & empty & accept: single-cycle op. core_rvalid_o[winner]=1, no push.
  - apu_rvalid_i & empty & !accept: err_o=1, response dropped.
- Push: winner ID on accept, unless the single-cycle case above applies.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: modulo TAG_DEPTH.
- core_rdata_o = apu_rdata_i at all times.
- contention_o = accept & (popcount(core_req_i) > 1).
- busy_o = !empty.
- Ordering: the APU and the dispatchers guarantee in-order return, so no tag is sent to the APU.
- Reset mid-operation: FIFO contents are discarded. Responses arriving after reset with an empty FIFO and no accept raise err_o.

Test Plan:
- NUM_CORES=4, cores 0 and 2 request continuously, apu_gnt_i=1, no responses -> grants go 0,2,0,2. FIFO fills after 4 accepts, then apu_req_o=0. contention_o=1 on each of the 4 accepts.
- Full FIFO (owners 0,2,0,2), one apu_rvalid_i per cycle -> core_rvalid_o = 0001, 0100, 0001, 0100. busy_o falls the cycle after the 4th pop. Grants resume one cycle after the first pop.
- Core 3 only, apu_gnt_i=1 and apu_rvalid_i=1 in the same cycle, FIFO empty -> core_rvalid_o=1000, count stays 0, err_o=0.
- apu_gnt_i=0 for 3 cycles with cores 1 and 3 requesting -> core_gnt_o=0, rr_ptr unchanged. On gnt, core 1 wins and the next accept goes to core 3.
- apu_rvalid_i=1 with FIFO empty and no accept -> err_o=1 for one cycle, all core_rvalid_o=0.
- Two ops outstanding, rst_ni=0 for one cycle -> busy_o=0, count=0 and rr_ptr=0 after the reset edge. A following stray apu_rvalid_i raises err_o.
